// File: rtl/echo_delay_line.sv
// Echo/delay unit: circular sample buffer read back delay_len samples earlier,
// scaled by gain and mixed with the live input, with hardware buffer clearing.
module echo_delay_line #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int GAIN_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [GAIN_W-1:0] gain,
    input  logic              feedback,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int WIDE_W = DATA_W + GAIN_W + 1;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(GAIN_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(GAIN_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_MIX   = 2'd3
    } state_t;

    // The mix sum always fits in DATA_W+1 bits, so clamping the wide value is exact.
    function automatic logic [DATA_W-1:0] saturate(input logic signed [WIDE_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            r = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              fb_q, fb_d;
    logic [DATA_W-1:0] dly_q, dly_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0]        dly_len_s;
    logic signed [WIDE_W-1:0] mix_wide_s;
    logic signed [WIDE_W-1:0] sum_wide_s;
    logic [DATA_W-1:0]        sat_s;

    // Delay clamp and mix datapath (signed sample times unsigned gain).
    always_comb begin
        if (delay_len == {ADDR_W{1'b0}}) begin
            dly_len_s = {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            dly_len_s = delay_len;
        end
        mix_wide_s = ($signed(dly_q) * $signed({1'b0, gain_q})) >>> GAIN_W;
        sum_wide_s = mix_wide_s + WIDE_W'($signed(smp_q));
        sat_s      = saturate(sum_wide_s);
    end

    // Next-state, buffer access and output computation.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        smp_d       = smp_q;
        gain_d      = gain_q;
        fb_d        = fb_q;
        dly_d       = dly_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_raddr   = wr_ptr_q - dly_len_s;
        mem_wdata   = smp_q;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = {DATA_W{1'b0}};
                clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d  = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                // A flush request takes priority over a simultaneous sample.
                if (flush) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = {ADDR_W{1'b0}};
                end else if (in_valid) begin
                    smp_d   = in_data;
                    gain_d  = gain;
                    fb_d    = feedback;
                    mem_re  = 1'b1;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                dly_d   = mem_rdata_q;
                state_d = ST_MIX;
            end
            ST_MIX: begin
                out_data_d  = sat_s;
                out_valid_d = 1'b1;
                mem_we      = 1'b1;
                if (fb_q) begin
                    mem_wdata = sat_s;
                end else begin
                    mem_wdata = smp_q;
                end
                wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                state_d  = ST_IDLE;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_CLEAR);
    end

    // Sample buffer with registered read port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata_q <= mem[mem_raddr];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= {ADDR_W{1'b0}};
            wr_ptr_q    <= {ADDR_W{1'b0}};
            smp_q       <= {DATA_W{1'b0}};
            gain_q      <= {GAIN_W{1'b0}};
            fb_q        <= 1'b0;
            dly_q       <= {DATA_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            smp_q       <= smp_d;
            gain_q      <= gain_d;
            fb_q        <= fb_d;
            dly_q       <= dly_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_echo_delay_line.sv
// Scoreboard bench for echo_delay_line: directed samples push expected outputs,
// a negedge monitor pops and compares data and arrival cycle.
module tb_echo_delay_line;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  delay_len;
    logic [7:0]  gain;
    logic        feedback;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    echo_delay_line #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .GAIN_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .delay_len (delay_len),
        .gain      (gain),
        .feedback  (feedback),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", out_data, 32'h0000_0000);
                if (out_data == 32'h0000_0000) begin
                    errors++;
                    $display("FAIL unexpected_out_valid: got pulse expected none");
                end
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_clear();
        for (int k = 1; k <= 256; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            if (k < 256) begin
                chk("clear_busy_ready", {30'd0, busy, in_ready}, 32'd2);
            end else begin
                chk("clear_done", {30'd0, busy, in_ready}, 32'd1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] dl, input logic [7:0] g,
                        input logic fb, input logic [31:0] exp);
        exp_t e;
        wait_ready();
        in_valid  = 1'b1;
        in_data   = d;
        delay_len = dl;
        gain      = g;
        feedback  = fb;
        e.data    = exp;
        e.cyc     = cyc + 3;
        q.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic do_flush();
        wait_ready();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        wait_clear();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {in_ready, out_valid, busy, 29'd0}, {1'b0, 1'b0, 1'b1, 29'd0});
        chk({name, "_data"}, out_data, 32'h0000_0000);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        delay_len = 8'd1;
        gain      = 8'd0;
        feedback  = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_state");
        reset_n = 1'b1;
        wait_clear();

        // Single echo, d=3, gain 1/2.
        send(32'd1000, 8'd3, 8'd128, 1'b0, 32'd1000);
        send(32'd0,    8'd3, 8'd128, 1'b0, 32'd0);
        send(32'd0,    8'd3, 8'd128, 1'b0, 32'd0);
        send(32'd0,    8'd3, 8'd128, 1'b0, 32'd500);
        send(32'd0,    8'd3, 8'd128, 1'b0, 32'd0);
        send(32'd0,    8'd3, 8'd128, 1'b0, 32'd0);
        drain();

        // delay_len 0 behaves as 1.
        do_flush();
        send(32'd200, 8'd0, 8'd128, 1'b0, 32'd200);
        send(32'd0,   8'd0, 8'd128, 1'b0, 32'd100);
        send(32'd40,  8'd0, 8'd128, 1'b0, 32'd40);
        send(32'd0,   8'd1, 8'd128, 1'b0, 32'd20);
        drain();

        // d=255 across the pointer wrap: in[i]=i+1, echo of in[i-255] halved.
        do_flush();
        for (int i = 0; i < 600; i++) begin
            int e;
            e = (i + 1) + ((i >= 255) ? ((i - 254) >> 1) : 0);
            send(32'(i + 1), 8'd255, 8'd128, 1'b0, 32'(e));
        end
        drain();

        // After a flush the wrap data at index 255 must be gone.
        do_flush();
        send(32'd0, 8'd1, 8'd128, 1'b0, 32'd0);

        // Repeating echo decays by half each sample.
        send(32'd1024, 8'd1, 8'd128, 1'b1, 32'd1024);
        for (int i = 9; i >= 0; i--) begin
            send(32'd0, 8'd1, 8'd128, 1'b1, 32'(1 << i));
        end
        send(32'd0, 8'd1, 8'd128, 1'b1, 32'd0);

        // Saturation both ways, then arithmetic-shift rounding of negatives.
        send(32'h7FFF_0000, 8'd1, 8'd0,   1'b0, 32'h7FFF_0000);
        send(32'h7FFF_0000, 8'd1, 8'd255, 1'b0, 32'h7FFF_FFFF);
        send(32'h8001_0000, 8'd1, 8'd0,   1'b0, 32'h8001_0000);
        send(32'h8001_0000, 8'd1, 8'd255, 1'b0, 32'h8000_0000);
        send(-32'sd300,     8'd1, 8'd0,   1'b1, -32'sd300);
        send(32'd0,         8'd1, 8'd128, 1'b1, -32'sd150);
        send(32'd0,         8'd1, 8'd128, 1'b1, -32'sd75);
        send(32'd0,         8'd1, 8'd128, 1'b1, -32'sd38);
        drain();

        // Reset asserted while the sample is in MIX: no output, reset values.
        wait_ready();
        in_valid  = 1'b1;
        in_data   = 32'd5555;
        delay_len = 8'd1;
        gain      = 8'd128;
        feedback  = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("midop_reset_hold");
        reset_n = 1'b1;
        wait_clear();
        send(32'd77, 8'd1, 8'd128, 1'b0, 32'd77);
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
